// File: rtl/rem_seq_ctrl.sv
// rem_seq_ctrl: sequential sign-magnitude divider; a restoring shift-subtract loop
// retires one quotient bit per cycle, with a valid/ready handshake on both sides.
module rem_seq_ctrl #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W:0]   rem_out,
    output logic [W:0]   quo_out,
    output logic         negF,
    output logic         zerF,
    output logic         DZF,
    output logic         busy
);
    localparam int M = W - 1;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t state, stateNext;
    logic [W-1:0] aReg, bReg;
    logic [M-1:0] partRem, quoShift, partRemNext, quoShiftNext;
    logic [CW-1:0] cnt;
    logic [M:0] shifted;
    logic quoBit, remSign, quoSign, divZero;

    // The quotient register starts as the dividend and shifts its bits out MSB first.
    always_comb begin
        divZero = bReg[M-1:0] == '0;
        shifted = {partRem, quoShift[M-1]};
        quoBit = shifted >= {1'b0, bReg[M-1:0]};
        partRemNext = quoBit ? M'(shifted - {1'b0, bReg[M-1:0]}) : shifted[M-1:0];
        quoShiftNext = M'({quoShift, quoBit});
        remSign = aReg[W-1] && partRemNext != '0;
        quoSign = (aReg[W-1] ^ bReg[W-1]) && quoShiftNext != '0;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: stateNext = start_valid ? LOAD : IDLE;
            LOAD: stateNext = divZero ? DONE : ITER;
            ITER: stateNext = (cnt == '0) ? DONE : ITER;
            DONE: stateNext = res_ready ? IDLE : DONE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= stateNext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aReg <= '0;
            bReg <= '0;
            partRem <= '0;
            quoShift <= '0;
            cnt <= '0;
            rem_out <= '0;
            quo_out <= '0;
            zerF <= 1'b0;
            DZF <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        aReg <= op_a;
                        bReg <= op_b;
                    end
                end
                LOAD: begin
                    partRem <= '0;
                    quoShift <= aReg[M-1:0];
                    cnt <= CW'(M - 1);
                    if (divZero) begin
                        rem_out <= '0;
                        quo_out <= '0;
                        zerF <= 1'b1;
                        DZF <= 1'b1;
                    end
                end
                ITER: begin
                    partRem <= partRemNext;
                    quoShift <= quoShiftNext;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        rem_out <= {remSign, 1'b0, partRemNext};
                        quo_out <= {quoSign, 1'b0, quoShiftNext};
                        zerF <= partRemNext == '0;
                        DZF <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready = state == IDLE;
    assign busy = state != IDLE;
    assign res_valid = state == DONE;
    assign negF = rem_out[W];
endmodule

// File: tb/tb_rem_seq_ctrl.sv
// tb_rem_seq_ctrl: directed and random division requests checked against an
// arithmetic reference model, including backpressure and mid-operation reset.
module tb_rem_seq_ctrl;
    localparam int W = 3;
    localparam int M = W - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_valid = 1'b0;
    logic res_ready = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic start_ready, res_valid, negF, zerF, DZF, busy;
    logic [W:0] rem_out, quo_out;
    int nChecks = 0;
    int nFail = 0;

    rem_seq_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
        .rem_out(rem_out), .quo_out(quo_out), .negF(negF), .zerF(zerF), .DZF(DZF), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W:0] r, output logic [W:0] q,
                            output logic n, output logic z, output logic d);
        int am, bm, rm, qm;
        am = a[W-2:0];
        bm = b[W-2:0];
        d = bm == 0;
        rm = d ? 0 : am % bm;
        qm = d ? 0 : am / bm;
        r = {a[W-1] && rm != 0, 1'b0, M'(rm)};
        q = {(a[W-1] ^ b[W-1]) && qm != 0, 1'b0, M'(qm)};
        n = r[W];
        z = rm == 0;
    endtask

    task automatic checkResult(input string tag, input logic [W:0] r, input logic [W:0] q,
                               input logic n, input logic z, input logic d);
        check({tag, "_rem"}, rem_out, r);
        check({tag, "_quo"}, quo_out, q);
        check({tag, "_negF"}, negF, n);
        check({tag, "_zerF"}, zerF, z);
        check({tag, "_DZF"}, DZF, d);
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE with start_valid low.
    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W:0] er, eq;
        logic en, ez, ed;
        int lat;
        refModel(a, b, er, eq, en, ez, ed);
        check("ready_idle", start_ready, 1);
        op_a = a;
        op_b = b;
        start_valid = 1'b1;
        res_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_valid = 1'($urandom_range(0, 1));
        check("ready_low_busy", start_ready, 0);
        check("busy_high", busy, 1);
        while (!res_valid && lat < 20) begin
            op_a = W'($urandom);
            op_b = W'($urandom);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, ed ? 2 : M + 2);
        checkResult("result", er, eq, en, ez, ed);
        start_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_ready_low", start_ready, 0);
            checkResult("hold", er, eq, en, ez, ed);
        end
        op_a = a;
        op_b = b;
        res_ready = 1'b1;
        check("ready_low_on_release", start_ready, 0);
        @(negedge clk);
        res_ready = 1'b0;
        check("valid_drop", res_valid, 0);
        check("ready_after_done", start_ready, 1);
        checkResult("kept", er, eq, en, ez, ed);
        @(negedge clk);
        start_valid = 1'b0;
        check("accept_next_cycle", busy, 1);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("repeat_valid", res_valid, 1);
        checkResult("repeat", er, eq, en, ez, ed);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_rem", rem_out, 0);
        check("rst_quo", quo_out, 0);
        check("rst_flags", {negF, zerF, DZF}, 0);
        check("rst_hs", {start_ready, busy, res_valid}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        runOp(3'b011, 3'b010, 0);
        runOp(3'b111, 3'b010, 1);
        runOp(3'b110, 3'b101, 0);
        runOp(3'b010, 3'b100, 0);
        runOp(3'b100, 3'b011, 2);
        runOp(3'b011, 3'b010, 5);
        for (int i = 0; i < 40; i++)
            runOp(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        runOp(3'b111, 3'b010, 0);
        op_a = 3'b011;
        op_b = 3'b010;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_rem", rem_out, 0);
        check("abort_quo", quo_out, 0);
        check("abort_flags", {negF, zerF, DZF}, 0);
        check("abort_hs", {start_ready, busy, res_valid}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_valid", res_valid, 0);
        end
        runOp(3'b011, 3'b010, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
